// File: rtl/mm_ctrl_input_pkg.sv
// Shared constants for the console/controller input conditioner: raw switch
// bit indices, RIOT PB bit positions and the PB word builder.
package mm_ctrl_input_pkg;

  localparam int unsigned NUM_JOY = 8;
  localparam int unsigned NUM_SW  = 5;
  localparam int unsigned NUM_RAW = NUM_JOY + NUM_SW;

  localparam int unsigned SW_RESET  = 0;
  localparam int unsigned SW_SELECT = 1;
  localparam int unsigned SW_COLOR  = 2;
  localparam int unsigned SW_P0DIFF = 3;
  localparam int unsigned SW_P1DIFF = 4;

  localparam int unsigned PB_RESET  = 0;
  localparam int unsigned PB_SELECT = 1;
  localparam int unsigned PB_COLOR  = 3;
  localparam int unsigned PB_P0DIFF = 6;
  localparam int unsigned PB_P1DIFF = 7;

  localparam logic [7:0] PB_UNUSED_MASK = 8'b0011_0100;

  // Unused PB positions read as released (1); switch bits keep their active-low sense.
  function automatic logic [7:0] pb_map(input logic [NUM_SW-1:0] sw);
    logic [7:0] pb;
    pb            = PB_UNUSED_MASK;
    pb[PB_RESET]  = sw[SW_RESET];
    pb[PB_SELECT] = sw[SW_SELECT];
    pb[PB_COLOR]  = sw[SW_COLOR];
    pb[PB_P0DIFF] = sw[SW_P0DIFF];
    pb[PB_P1DIFF] = sw[SW_P1DIFF];
    return pb;
  endfunction

endpackage

// File: rtl/mm_ctrl_input_debounce.sv
// Single-bit conditioner: 2-flop synchroniser, tick-sampled history and the
// accepted output level. CHG_BIT flags that Q flips on this edge.
module mm_debounce_bit #(
  parameter int unsigned STABLE = 4
) (
  input  logic CLK,
  input  logic RES,
  input  logic TICK,
  input  logic D,
  output logic Q,
  output logic CHG_BIT
);

  logic [1:0]        sync;
  logic [STABLE-2:0] hist;
  logic [STABLE-1:0] win;

  // Only the newest STABLE-1 samples are stored; the current synchronised
  // sample completes the STABLE-wide window.
  always_comb begin
    win     = {hist, sync[1]};
    CHG_BIT = 1'b0;
    if (TICK) begin
      CHG_BIT = ((&win) && !Q) || (!(|win) && Q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      sync <= '1;
      hist <= '1;
      Q    <= 1'b1;
    end else begin
      sync <= {sync[0], D};
      if (TICK) begin
        hist <= win[STABLE-2:0];
        if (CHG_BIT) begin
          Q <= ~Q;
        end
      end
    end
  end

endmodule

// File: rtl/mm_ctrl_input.sv
// Console/controller input conditioner: debounces 13 raw active-low contacts
// and presents them as RIOT PA/PB words plus a one-cycle change strobe.
module mm_ctrl_input
  import mm_ctrl_input_pkg::*;
#(
  parameter int unsigned TICK_DIV = 16,
  parameter int unsigned STABLE   = 4
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic [7:0] JOY_N,
  input  logic [4:0] SW_N,
  output logic [7:0] PA_IN,
  output logic [7:0] PB_IN,
  output logic       CHG
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]   count;
  logic               tick;
  logic [NUM_RAW-1:0] raw;
  logic [NUM_RAW-1:0] q;
  logic [NUM_RAW-1:0] chg_bit;

  assign tick = (count == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RES || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign raw = {SW_N, JOY_N};

  for (genvar i = 0; i < NUM_RAW; i++) begin : g_bit
    mm_debounce_bit #(.STABLE(STABLE)) u_bit (
      .CLK     (CLK),
      .RES     (RES),
      .TICK    (tick),
      .D       (raw[i]),
      .Q       (q[i]),
      .CHG_BIT (chg_bit[i])
    );
  end

  assign PA_IN = q[NUM_JOY-1:0];
  assign PB_IN = pb_map(q[NUM_RAW-1:NUM_JOY]);

  // Registered alongside the output flip, so CHG is high in the same cycle the new level is visible.
  always_ff @(posedge CLK) begin
    if (RES) begin
      CHG <= 1'b0;
    end else begin
      CHG <= |chg_bit;
    end
  end

endmodule

// File: tb/tb_mm_ctrl_input.sv
// Directed bench for mm_ctrl_input with three parameterisations sharing one clock.
module tb_mm_ctrl_input;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res_a, res_b, res_c;
  logic [7:0] joy_a, joy_b, joy_c;
  logic [4:0] sw_a, sw_b, sw_c;
  logic [7:0] pa_a, pa_b, pa_c, pb_a, pb_b, pb_c;
  logic       chg_a, chg_b, chg_c;

  mm_ctrl_input #(.TICK_DIV(1), .STABLE(3)) u_dut_a (
    .CLK(clk), .RES(res_a), .JOY_N(joy_a), .SW_N(sw_a),
    .PA_IN(pa_a), .PB_IN(pb_a), .CHG(chg_a)
  );

  mm_ctrl_input #(.TICK_DIV(4), .STABLE(3)) u_dut_b (
    .CLK(clk), .RES(res_b), .JOY_N(joy_b), .SW_N(sw_b),
    .PA_IN(pa_b), .PB_IN(pb_b), .CHG(chg_b)
  );

  mm_ctrl_input #(.TICK_DIV(2), .STABLE(4)) u_dut_c (
    .CLK(clk), .RES(res_c), .JOY_N(joy_c), .SW_N(sw_c),
    .PA_IN(pa_c), .PB_IN(pb_c), .CHG(chg_c)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int unsigned n_chg;
  logic        stayed;

  initial begin
    res_a = 1'b1; res_b = 1'b1; res_c = 1'b1;
    joy_a = '0; joy_b = '0; joy_c = '0;
    sw_a  = '0; sw_b  = '0; sw_c  = '0;

    // Reset with all contacts pressed.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_pa_a", pa_a, 8'hFF);
      check("rst_pb_a", pb_a, 8'hFF);
      check("rst_chg_a", chg_a, 1'b0);
      check("rst_pb_b", pb_b, 8'hFF);
      check("rst_pa_c", pa_c, 8'hFF);
    end
    res_a = 1'b0; res_b = 1'b0; res_c = 1'b0;
    joy_a = '1; joy_b = '1; joy_c = '1;
    sw_a  = '1; sw_b  = '1; sw_c  = '1;
    step();
    check("post_rst_pa_a", pa_a, 8'hFF);
    check("post_rst_pb_a", pb_a, 8'hFF);
    check("post_rst_chg_a", chg_a, 1'b0);
    for (int i = 0; i < 6; i++) step();

    // TICK_DIV=1 STABLE=3: accepted 5 edges after the capture edge.
    joy_a[4] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k < 5) begin
        check("lat_pa_early", pa_a, 8'hFF);
        check("lat_chg_early", chg_a, 1'b0);
      end else if (k == 5) begin
        check("lat_pa_edge5", pa_a, 8'hEF);
        check("lat_chg_edge5", chg_a, 1'b1);
      end else begin
        check("lat_pa_edge6", pa_a, 8'hEF);
        check("lat_chg_edge6", chg_a, 1'b0);
      end
    end
    joy_a[4] = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("release_pa", pa_a, 8'hFF);

    // Two-cycle glitch is rejected.
    joy_a[0] = 1'b0;
    step();
    step();
    joy_a[0] = 1'b1;
    n_chg = 0;
    stayed = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (chg_a) n_chg++;
      if (pa_a !== 8'hFF) stayed = 1'b0;
    end
    check("glitch_pa_stable", {15'd0, stayed}, 16'd1);
    check("glitch_chg_cnt", 16'(n_chg), 16'd0);

    // TICK_DIV=4 STABLE=3: all switches pressed, accept in [11,14] edges.
    res_b = 1'b1;
    step();
    res_b = 1'b0;
    sw_b  = 5'b00000;
    n_chg = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (chg_b) n_chg++;
      if (k <= 10) check("div4_pb_early", pb_b, 8'hFF);
      if (k == 14) check("div4_pb_by14", pb_b, 8'h34);
    end
    check("div4_pb_final", pb_b, 8'h34);
    check("div4_chg_cnt", 16'(n_chg), 16'd1);

    // Reset in the middle of debouncing SELECT restarts full latency.
    sw_a[1] = 1'b0;
    step();
    step();
    res_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("mid_rst_pb", pb_a, 8'hFF);
      check("mid_rst_chg", chg_a, 1'b0);
    end
    res_a = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k < 5) check("mid_pb_early", pb_a, 8'hFF);
      if (k == 5) begin
        check("mid_pb_edge5", pb_a, 8'hFD);
        check("mid_chg_edge5", chg_a, 1'b1);
      end
      if (k == 6) check("mid_chg_edge6", chg_a, 1'b0);
    end

    // Bouncing contact (3-cycle runs) on TICK_DIV=2 STABLE=4, then settles low.
    res_c = 1'b1;
    step();
    res_c = 1'b0;
    n_chg = 0;
    stayed = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) joy_c[7] = ~joy_c[7];
      step();
      if (chg_c) n_chg++;
      if (pa_c !== 8'hFF) stayed = 1'b0;
    end
    check("bounce_pa_stable", {15'd0, stayed}, 16'd1);
    joy_c[7] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (chg_c) n_chg++;
    end
    check("bounce_pa_final", pa_c, 8'h7F);
    check("bounce_chg_cnt", 16'(n_chg), 16'd1);
    check("bounce_pb_c", pb_c, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
